systolic_sched: RTL and testbench

Top-level sequencer for the systolic matrix-multiply array. On a start request it walks every (A row-slice, B column-slice) tile pair and generates the read enables and addresses for the A and B operand banks. It also generates the per-tile init strobe that seeds the PE accumulators. On the output side it counts the valid_D results from each array row, generates the write enables and addresses for the D result banks, and reports done, or error if results fail to arrive.

---
 rtl/systolic_pkg.sv | 26 ++
 rtl/sched_row_wr.sv | 46 ++++
 rtl/systolic_sched.sv | 188 ++++++++++++++++++
 tb/tb_systolic_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic array sequencer.
package systolic_pkg;

  // Sequencer phases: idle, operand streaming, result drain, completion.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    FIN    = 2'd3
  } sched_state_t;

  // Address width of an A bank (and of a D bank), never narrower than one bit.
  function automatic int aw_a(input int m, input int n1);
    int w;
    w = $clog2((m * m) / n1);
    return (w < 1) ? 1 : w;
  endfunction

  // Address width of a B bank, never narrower than one bit.
  function automatic int aw_b(input int m, input int n2);
    int w;
    w = $clog2((m * m) / n2);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sched_row_wr.sv
// Per-row D bank writer: passes the row's result valid through as a write
// enable and keeps a saturating write counter that serves as the D address.
module sched_row_wr #(
  parameter int AW = 4,
  parameter int E  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          active,
  input  logic          valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          complete
);

  // The counter is one bit wider than the address so it can hold E itself.
  localparam logic [AW:0] E_CNT = E[AW:0];

  logic [AW:0] cnt_q;
  logic [AW:0] cnt_d;

  assign complete = (cnt_q == E_CNT);
  assign wr_en    = active & valid & ~complete;
  assign wr_addr  = cnt_q[AW-1:0];

  // Next count: cleared while the sequencer idles, advanced on every accepted write.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wr_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Write counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/systolic_sched.sv
// Top-level sequencer for the systolic matrix-multiply array: walks every
// (A row-slice, B column-slice) tile pair to stream operands, then collects
// the per-row results into the D banks and reports done or a drain timeout.
module systolic_sched
  import systolic_pkg::*;
#(
  parameter int  N1        = 4,
  parameter int  N2        = 4,
  parameter int  M         = 8,
  parameter int  DRAIN_MAX = 32,
  localparam int AW_A      = aw_a(M, N1),
  localparam int AW_B      = aw_b(M, N2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               rd_en,
  output logic [AW_A-1:0]    rd_addr_A,
  output logic [AW_B-1:0]    rd_addr_B,
  output logic               tile_init,
  input  logic [N1-1:0]      valid_D,
  output logic [N1-1:0]      wr_en_D,
  output logic [N1*AW_A-1:0] wr_addr_D
);

  localparam int E   = (M * M) / N1;
  localparam int KW  = ($clog2(M) < 1) ? 1 : $clog2(M);
  localparam int SAW = ($clog2(M / N1) < 1) ? 1 : $clog2(M / N1);
  localparam int SBW = ($clog2(M / N2) < 1) ? 1 : $clog2(M / N2);
  localparam int TW  = ($clog2(DRAIN_MAX) < 1) ? 1 : $clog2(DRAIN_MAX);

  localparam logic [KW-1:0]   K_LAST  = KW'(M - 1);
  localparam logic [SAW-1:0]  SA_LAST = SAW'((M / N1) - 1);
  localparam logic [SBW-1:0]  SB_LAST = SBW'((M / N2) - 1);
  localparam logic [TW-1:0]   T_LAST  = TW'(DRAIN_MAX - 1);
  localparam logic [AW_A-1:0] M_A     = AW_A'(M);
  localparam logic [AW_B-1:0] M_B     = AW_B'(M);

  sched_state_t    state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [SAW-1:0]  sa_q, sa_d;
  logic [SBW-1:0]  sb_q, sb_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            rd_en_q, rd_en_d;
  logic            tile_init_q, tile_init_d;
  logic [AW_A-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [AW_B-1:0] rd_addr_b_q, rd_addr_b_d;

  logic            row_clr;
  logic            row_active;
  logic [N1-1:0]   row_done;
  logic            all_complete;

  assign row_clr      = (state_q == IDLE);
  assign row_active   = (state_q == STREAM) || (state_q == DRAIN);
  assign all_complete = &row_done;

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign rd_en     = rd_en_q;
  assign tile_init = tile_init_q;
  assign rd_addr_A = rd_addr_a_q;
  assign rd_addr_B = rd_addr_b_q;

  // One writer per array row; the drain phase ends once every row is complete.
  for (genvar i = 0; i < N1; i++) begin : g_row
    sched_row_wr #(
      .AW (AW_A),
      .E  (E)
    ) u_row (
      .clk      (clk),
      .rst      (rst),
      .clr      (row_clr),
      .active   (row_active),
      .valid    (valid_D[i]),
      .wr_en    (wr_en_D[i]),
      .wr_addr  (wr_addr_D[i*AW_A +: AW_A]),
      .complete (row_done[i])
    );
  end

  // Next state, tile walk counters, drain timer and the registered outputs.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    timer_d     = timer_q;
    error_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        k_d     = '0;
        sa_d    = '0;
        sb_d    = '0;
        timer_d = '0;
        if (start) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (k_q == K_LAST) begin
          k_d = '0;
          if (sb_q == SB_LAST) begin
            sb_d = '0;
            if (sa_q == SA_LAST) begin
              sa_d    = '0;
              timer_d = '0;
              state_d = DRAIN;
            end else begin
              sa_d = sa_q + 1'b1;
            end
          end else begin
            sb_d = sb_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (all_complete) begin
          state_d = FIN;
        end else if (timer_q == T_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d == STREAM) || (state_d == DRAIN);
    done_d      = (state_d == FIN);
    rd_en_d     = (state_d == STREAM);
    tile_init_d = rd_en_d && (k_d == K_LAST);
    rd_addr_a_d = '0;
    rd_addr_b_d = '0;
    if (rd_en_d) begin
      rd_addr_a_d = AW_A'(sa_d) * M_A + AW_A'(k_d);
      rd_addr_b_d = AW_B'(sb_d) * M_B + AW_B'(k_d);
    end
  end

  // Sequencer registers; reset aborts any run without a done or error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      tile_init_q <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      rd_en_q     <= rd_en_d;
      tile_init_q <= tile_init_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
    end
  end

endmodule

// File: tb/tb_systolic_sched.sv
// Self-checking bench for systolic_sched: operand read sequence and D writes
// are predicted from the tile walk and per-row result counts, queued, and
// compared by an independent monitor whenever the DUT asserts rd_en/wr_en_D.
module tb_systolic_sched;
  import systolic_pkg::*;

  localparam int N1        = 4;
  localparam int N2        = 4;
  localparam int M         = 8;
  localparam int DRAIN_MAX = 32;
  localparam int AW_A      = aw_a(M, N1);
  localparam int AW_B      = aw_b(M, N2);
  localparam int E         = (M * M) / N1;

  logic               clk;
  logic               rst;
  logic               start;
  logic               busy;
  logic               done;
  logic               error;
  logic               rd_en;
  logic [AW_A-1:0]    rd_addr_A;
  logic [AW_B-1:0]    rd_addr_B;
  logic               tile_init;
  logic [N1-1:0]      valid_D;
  logic [N1-1:0]      wr_en_D;
  logic [N1*AW_A-1:0] wr_addr_D;

  typedef struct {
    int a;
    int b;
    int ti;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      wr_q[N1][$];

  int   checks      = 0;
  int   errors      = 0;
  int   cyc         = 0;
  int   done_count  = 0;
  int   error_count = 0;
  int   error_cyc   = 0;
  int   drain_cyc   = 0;
  logic prev_rd_en  = 1'b0;

  systolic_sched #(
    .N1        (N1),
    .N2        (N2),
    .M         (M),
    .DRAIN_MAX (DRAIN_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .rd_en     (rd_en),
    .rd_addr_A (rd_addr_A),
    .rd_addr_B (rd_addr_B),
    .tile_init (tile_init),
    .valid_D   (valid_D),
    .wr_en_D   (wr_en_D),
    .wr_addr_D (wr_addr_D)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time the drain timeout.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reads operands or writes results.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        if (rd_q.size() == 0) begin
          report_fail("rd_en_unexpected", 1, 0);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check_output("rd_addr_A", 32'(rd_addr_A), e.a);
          check_output("rd_addr_B", 32'(rd_addr_B), e.b);
          check_output("tile_init", 32'(tile_init), e.ti);
        end
      end else if (tile_init) begin
        report_fail("tile_init_outside_stream", 1, 0);
      end
      if (prev_rd_en && !rd_en) drain_cyc = cyc;
      for (int i = 0; i < N1; i++) begin
        if (wr_en_D[i]) begin
          if (wr_q[i].size() == 0) begin
            report_fail($sformatf("wr_en_D[%0d]_unexpected", i), 1, 0);
          end else begin
            check_output($sformatf("wr_addr_D[%0d]", i), 32'(wr_addr_D[i*AW_A +: AW_A]),
                         wr_q[i].pop_front());
          end
        end
      end
      if (done) begin
        done_count++;
        check_output("busy_at_done", 32'(busy), 0);
      end
      if (error) begin
        error_count++;
        error_cyc = cyc;
        check_output("busy_at_error", 32'(busy), 0);
      end
    end
    prev_rd_en = rd_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_queues();
    rd_q.delete();
    for (int i = 0; i < N1; i++) wr_q[i].delete();
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_busy"}, 32'(busy), 0);
    check_output({tag, "_done"}, 32'(done), 0);
    check_output({tag, "_error"}, 32'(error), 0);
    check_output({tag, "_rd_en"}, 32'(rd_en), 0);
    check_output({tag, "_tile_init"}, 32'(tile_init), 0);
    check_output({tag, "_rd_addr_A"}, 32'(rd_addr_A), 0);
    check_output({tag, "_rd_addr_B"}, 32'(rd_addr_B), 0);
    check_output({tag, "_wr_en_D"}, 32'(wr_en_D), 0);
    check_output({tag, "_wr_addr_D"}, 32'(wr_addr_D), 0);
  endtask

  // Reference operand order: A slice outer, B slice inner, k innermost.
  task automatic push_stream();
    rd_exp_t e;
    for (int sa = 0; sa < M / N1; sa++)
      for (int sb = 0; sb < M / N2; sb++)
        for (int k = 0; k < M; k++) begin
          e.a  = sa * M + k;
          e.b  = sb * M + k;
          e.ti = (k == M - 1) ? 1 : 0;
          rd_q.push_back(e);
        end
  endtask

  task automatic begin_run();
    push_stream();
    check_output("busy_before_start", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("busy_after_start", 32'(busy), 1);
    check_output("rd_en_after_start", 32'(rd_en), 1);
  endtask

  // Array model: each row emits tgt[i] valids with random gaps from cycle st[i],
  // finishing before cycle dl[i]; writes beyond E per row must be dropped.
  task automatic apply_stimulus(input int tgt[N1], input int st[N1], input int dl[N1],
                                input int start_at);
    int            sent[N1];
    logic [N1-1:0] v;
    bit            all_sent;
    for (int i = 0; i < N1; i++) sent[i] = 0;
    all_sent = 1'b0;
    for (int c = 0; c < 150; c++) begin
      v = '0;
      for (int i = 0; i < N1; i++) begin
        if (sent[i] < tgt[i] && c >= st[i]) begin
          if ((tgt[i] - sent[i] >= dl[i] - c) || ($urandom_range(0, 3) != 0)) v[i] = 1'b1;
        end
      end
      valid_D = v;
      start   = (c == start_at);
      for (int i = 0; i < N1; i++)
        if (v[i] && sent[i] < E) wr_q[i].push_back(sent[i]);
      #1;
      for (int i = 0; i < N1; i++) begin
        if (v[i]) begin
          check_output($sformatf("wr_en_D[%0d]_gate", i), 32'(wr_en_D[i]),
                       (sent[i] < E) ? 1 : 0);
          sent[i]++;
        end
      end
      @(posedge clk);
      #1;
      all_sent = 1'b1;
      for (int i = 0; i < N1; i++) if (sent[i] < tgt[i]) all_sent = 1'b0;
      if (all_sent && c >= start_at) break;
    end
    valid_D = '0;
    start   = 1'b0;
    if (!all_sent) report_fail("array_driver_timeout", 0, 1);
  endtask

  // Waits (bounded) for done or error, then checks pulse counts and timing.
  task automatic check_output_end(input bit expect_error, input bit start_in_fin);
    int d0;
    int e0;
    bit seen;
    d0   = done_count;
    e0   = error_count;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (done || error) begin
        seen = 1'b1;
        if (start_in_fin) start = 1'b1;
        tick();
        start = 1'b0;
        check_output("busy_after_end", 32'(busy), 0);
        check_output("rd_en_after_end", 32'(rd_en), 0);
        break;
      end
      tick();
    end
    if (!seen) report_fail("wait_end_timeout", 0, 1);
    repeat (4) tick();
    check_output("busy_idle", 32'(busy), 0);
    check_output("done_pulses", done_count - d0, expect_error ? 0 : 1);
    check_output("error_pulses", error_count - e0, expect_error ? 1 : 0);
    if (expect_error) check_output("error_latency", error_cyc - drain_cyc, DRAIN_MAX);
    check_output("rd_q_left", 32'(rd_q.size()), 0);
    for (int i = 0; i < N1; i++)
      check_output($sformatf("wr_q[%0d]_left", i), 32'(wr_q[i].size()), 0);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual %0d required %0d", cyc, 0);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tgt[N1];
    int st[N1];
    int dl[N1];
    int d0;
    int e0;

    rst     = 1'b1;
    start   = 1'b0;
    valid_D = '0;
    repeat (3) tick();
    rst = 1'b0;
    flush_queues();
    #1;
    check_idle("reset");

    $display("[TB] basic stream, result collection, start during FIN");
    tgt = '{16, 16, 16, 16};
    st  = '{0, 0, 0, 0};
    dl  = '{56, 56, 56, 56};
    begin_run();
    apply_stimulus(tgt, st, dl, -1);
    check_output_end(1'b0, 1'b1);

    $display("[TB] extra valid on row 0");
    tgt = '{17, 16, 16, 16};
    st  = '{0, 20, 20, 20};
    dl  = '{30, 56, 56, 56};
    begin_run();
    apply_stimulus(tgt, st, dl, -1);
    check_output_end(1'b0, 1'b0);

    $display("[TB] drain timeout with row 2 short");
    tgt = '{16, 16, 15, 16};
    st  = '{0, 0, 0, 0};
    dl  = '{56, 56, 56, 56};
    begin_run();
    apply_stimulus(tgt, st, dl, -1);
    check_output_end(1'b1, 1'b0);

    $display("[TB] start while busy");
    tgt = '{16, 16, 16, 16};
    begin_run();
    apply_stimulus(tgt, st, dl, 10);
    check_output_end(1'b0, 1'b0);

    $display("[TB] reset mid-stream");
    d0 = done_count;
    e0 = error_count;
    begin_run();
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flush_queues();
    check_idle("midreset");
    repeat (3) tick();
    check_output("midreset_no_done", done_count - d0, 0);
    check_output("midreset_no_error", error_count - e0, 0);
    begin_run();
    apply_stimulus(tgt, st, dl, -1);
    check_output_end(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
